// File: rtl/fifo_out_pkg.sv
// Shared definitions for the FFT return-path packer: input FSM encodings,
// a constant clog2, and the bit positions of the two points in a packed word.
package fifo_out_pkg;

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'b001,
        KEEP       = 3'b010,
        DISCARD    = 3'b100
    } state_e;

    localparam int POINT_W     = 16;
    localparam int WORD_W      = 32;
    localparam int PACK_HI_MSB = 31;
    localparam int PACK_HI_LSB = 16;
    localparam int PACK_LO_MSB = 15;
    localparam int PACK_LO_LSB = 0;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Earlier point goes to the high half, later point to the low half.
    function automatic logic [WORD_W-1:0] pack_word(input logic [POINT_W-1:0] hi,
                                                    input logic [POINT_W-1:0] lo);
        logic [WORD_W-1:0] word;
        word = {WORD_W{1'b0}};
        word[PACK_HI_MSB:PACK_HI_LSB] = hi;
        word[PACK_LO_MSB:PACK_LO_LSB] = lo;
        return word;
    endfunction

endpackage

// File: rtl/fifo_out_pack_if.sv
// Bus bundle between the FFT output stream / 32-bit consumer and fifo_out_pack.
// Optional occupancy port rd_data_count exists only with FIFO_OUT_COUNT_EN.
interface fifo_out_pack_if #(
    parameter int DEPTH = 2048
);
    import fifo_out_pkg::*;

    logic [POINT_W-1:0] data_in;
    logic               data_in_valid;
    logic               rd_req;
    logic [WORD_W-1:0]  data_out;
    logic               data_out_valid;
    logic               empty;
    logic               full;
    logic               frame_done;
    logic               overflow;
`ifdef FIFO_OUT_COUNT_EN
    logic [clog2(DEPTH):0] rd_data_count;
`endif

    modport master (
        output data_in, data_in_valid, rd_req,
        input  data_out, data_out_valid, empty, full, frame_done, overflow
`ifdef FIFO_OUT_COUNT_EN
        , rd_data_count
`endif
    );

    modport slave (
        input  data_in, data_in_valid, rd_req,
        output data_out, data_out_valid, empty, full, frame_done, overflow
`ifdef FIFO_OUT_COUNT_EN
        , rd_data_count
`endif
    );

endinterface

// File: rtl/ring_buf_dp.sv
// Dual-port ring buffer with registered read. Owns pointers, occupancy and
// the empty/full flags. A write while full is only accepted if a read drains
// a slot on the same edge; otherwise it is reported through wr_drop.
// Optional count port exists only with FIFO_OUT_COUNT_EN.
module ring_buf_dp import fifo_out_pkg::*; #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full
`ifdef FIFO_OUT_COUNT_EN
    , output logic [clog2(DEPTH):0] count
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    occ_r;
    logic [CW-1:0]    occ_next_s;
    logic             empty_r;
    logic             full_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;
    logic             rd_ok_s;
    logic             wr_ok_s;

    // Accept decisions: a read needs data, a write needs room or a same-edge read.
    always_comb begin
        rd_ok_s    = rd_req && !empty_r;
        wr_ok_s    = wr_en && (!full_r || rd_ok_s);
        occ_next_s = occ_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   occ_next_s = occ_r + CW'(1);
            2'b01:   occ_next_s = occ_r - CW'(1);
            default: occ_next_s = occ_r;
        endcase
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy, flags and the registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            occ_r      <= {CW{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            rd_valid_r <= rd_ok_s;
            occ_r      <= occ_next_s;
            empty_r    <= (occ_next_s == {CW{1'b0}});
            full_r     <= (occ_next_s == FULL_CNT);
        end
    end

    assign wr_drop  = wr_en && !wr_ok_s;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign empty    = empty_r;
    assign full     = full_r;
`ifdef FIFO_OUT_COUNT_EN
    assign count    = occ_r;
`endif

endmodule

// File: rtl/fifo_out_pack.sv
// FFT return-path packer: keeps the first KEEP_LENGTH points of every NFFT
// point frame, pairs them into 32-bit words and buffers them for a 32-bit
// consumer. Optional macro FIFO_OUT_COUNT_EN exposes the buffer occupancy
// as rd_data_count.
module fifo_out_pack import fifo_out_pkg::*; #(
    parameter int NFFT        = 1024,
    parameter int KEEP_LENGTH = 512,
    parameter int DEPTH       = 2048
) (
    input  logic          clk,
    input  logic          rst,
    fifo_out_pack_if.slave bus
);

    localparam int CW = clog2(NFFT);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NFFT - 1);
    localparam logic [CW-1:0] KEEP_LAST = CW'(KEEP_LENGTH - 1);
    localparam bit            KEEP_ALL  = (KEEP_LENGTH == NFFT);

    state_e             state_r;
    logic [CW-1:0]      cnt_r;
    logic [POINT_W-1:0] pack_hi_r;
    logic               frame_done_r;
    logic               overflow_r;
    logic               capture_s;
    logic               wr_en_s;
    logic               wr_drop_s;
    logic [WORD_W-1:0]  wr_data_s;

    // Capture decision: the very first point after reset is index 0 and is kept.
    always_comb begin
        wr_data_s = pack_word(pack_hi_r, bus.data_in);
        if (bus.data_in_valid && (state_r != DISCARD)) begin
            capture_s = 1'b1;
            wr_en_s   = cnt_r[0];
        end else begin
            capture_s = 1'b0;
            wr_en_s   = 1'b0;
        end
    end

    // Framing FSM, point counter, pack register and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= WAIT_FRAME;
            cnt_r        <= {CW{1'b0}};
            pack_hi_r    <= {POINT_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (bus.data_in_valid) begin
                cnt_r        <= cnt_r + CW'(1);
                frame_done_r <= (cnt_r == LAST_IDX) && (state_r != WAIT_FRAME);
                if (capture_s && !cnt_r[0]) begin
                    pack_hi_r <= bus.data_in;
                end
                case (state_r)
                    WAIT_FRAME: state_r <= KEEP;
                    KEEP: begin
                        if ((cnt_r == KEEP_LAST) && !KEEP_ALL) begin
                            state_r <= DISCARD;
                        end else begin
                            state_r <= KEEP;
                        end
                    end
                    DISCARD: begin
                        if (cnt_r == LAST_IDX) begin
                            state_r <= KEEP;
                        end else begin
                            state_r <= DISCARD;
                        end
                    end
                    default: state_r <= WAIT_FRAME;
                endcase
            end
        end
    end

    // Sticky record of any packed word lost to a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (wr_drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    ring_buf_dp #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_data  (wr_data_s),
        .wr_drop  (wr_drop_s),
        .rd_req   (bus.rd_req),
        .rd_data  (bus.data_out),
        .rd_valid (bus.data_out_valid),
        .empty    (bus.empty),
        .full     (bus.full)
`ifdef FIFO_OUT_COUNT_EN
        , .count  (bus.rd_data_count)
`endif
    );

    assign bus.frame_done = frame_done_r;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_fifo_out_pack.sv
// Bench for fifo_out_pack with NFFT=8, KEEP_LENGTH=4, DEPTH=4. A queue-based
// reference model tracks kept points, packed words and the buffer contents.
`timescale 1ns/1ps
module tb_fifo_out_pack;

    localparam int NFFT  = 8;
    localparam int KEEP  = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fifo_out_pack_if #(.DEPTH(DEPTH)) bus ();

    fifo_out_pack #(
        .NFFT        (NFFT),
        .KEEP_LENGTH (KEEP),
        .DEPTH       (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q [$];
    int          idx;
    logic [15:0] hold;
    logic        m_ovf;
    logic [31:0] m_dout;
    logic        e_valid;
    logic        e_fd;

    int compared;
    int mismatched;

    task automatic model_reset();
        q.delete();
        idx     = 0;
        hold    = 16'h0000;
        m_ovf   = 1'b0;
        m_dout  = 32'h0000_0000;
        e_valid = 1'b0;
        e_fd    = 1'b0;
    endtask

    // Apply one cycle of stimulus and advance the model to the post-edge state.
    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        bus.data_in_valid = v;
        bus.data_in       = d;
        bus.rd_req        = r;
        e_valid = r && (q.size() > 0);
        if (e_valid) m_dout = q.pop_front();
        e_fd = 1'b0;
        if (v) begin
            if (idx < KEEP) begin
                if (idx % 2 == 0) hold = d;
                else if (q.size() < DEPTH) q.push_back({hold, d});
                else m_ovf = 1'b1;
            end
            e_fd = (idx == NFFT - 1);
            idx  = (idx + 1) % NFFT;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.data_in_valid = 1'b0;
        bus.data_in       = 16'h0000;
        bus.rd_req        = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        bus.data_in_valid = 1'b0;
        bus.data_in       = 16'h0000;
        bus.rd_req        = 1'b0;
        model_reset();
        #1;
        compared++; if (bus.data_out !== 32'h0) begin mismatched++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        compared++; if (bus.data_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus.data_out_valid); end
        compared++; if (bus.empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        compared++; if (bus.full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", bus.full); end
        compared++; if (bus.frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
`ifdef FIFO_OUT_COUNT_EN
        compared++; if (bus.rd_data_count !== 3'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", bus.rd_data_count); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] want;
        for (int i = 0; i < NFFT; i++) begin
            drive(1'b1, 16'(i + 1), 1'b0);
            compared++; if (bus.frame_done !== e_fd) begin mismatched++; $display("FAIL basic_frame_done pt %0d: got %b want %b", i, bus.frame_done, e_fd); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            want = (i == 0) ? 32'h0001_0002 : 32'h0003_0004;
            compared++; if (bus.data_out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid rd %0d: got %b want 1", i, bus.data_out_valid); end
            compared++; if (bus.data_out !== want) begin mismatched++; $display("FAIL basic_data rd %0d: got %h want %h", i, bus.data_out, want); end
            compared++; if (bus.frame_done !== 1'b0) begin mismatched++; $display("FAIL basic_fd_clear rd %0d: got %b want 0", i, bus.frame_done); end
        end
        drive(1'b0, 16'h0000, 1'b0);
        compared++; if (bus.empty !== 1'b1) begin mismatched++; $display("FAIL basic_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_gaps();
        int          pulses;
        logic [31:0] want;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 2 * NFFT; c++) begin
            drive((c % 2) == 0, 16'(c / 2 + 1), 1'b0);
            if (bus.frame_done === 1'b1) pulses++;
            compared++; if (bus.frame_done !== e_fd) begin mismatched++; $display("FAIL gaps_frame_done cyc %0d: got %b want %b", c, bus.frame_done, e_fd); end
        end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL gaps_pulse_count: got %0d want 1", pulses); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            want = (i == 0) ? 32'h0001_0002 : 32'h0003_0004;
            compared++; if (bus.data_out !== want || bus.data_out_valid !== 1'b1) begin mismatched++; $display("FAIL gaps_data rd %0d: got %h/%b want %h/1", i, bus.data_out, bus.data_out_valid, want); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 3 * NFFT; c++) begin
            drive(1'b1, 16'($urandom), 1'b0);
            compared++; if (bus.full !== (q.size() == DEPTH)) begin mismatched++; $display("FAIL ovf_full cyc %0d: got %b want %b", c, bus.full, q.size() == DEPTH); end
            compared++; if (bus.overflow !== m_ovf) begin mismatched++; $display("FAIL ovf_flag cyc %0d: got %b want %b", c, bus.overflow, m_ovf); end
        end
        compared++; if (bus.overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            compared++; if (bus.data_out !== m_dout || bus.data_out_valid !== 1'b1) begin mismatched++; $display("FAIL ovf_drain %0d: got %h/%b want %h/1", i, bus.data_out, bus.data_out_valid, m_dout); end
            compared++; if (bus.overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky %0d: got %b want 1", i, bus.overflow); end
        end
        compared++; if (bus.empty !== 1'b1) begin mismatched++; $display("FAIL ovf_empty_after: got %b want 1", bus.empty); end
    endtask

    task automatic test_full_rw();
        logic [15:0] d0;
        logic [15:0] d1;
        logic [31:0] new_word;
        do_reset();
        for (int c = 0; c < 2 * NFFT; c++) drive(1'b1, 16'($urandom), 1'b0);
        compared++; if (bus.full !== 1'b1) begin mismatched++; $display("FAIL fullrw_full: got %b want 1", bus.full); end
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        new_word = {d0, d1};
        drive(1'b1, d0, 1'b0);
        drive(1'b1, d1, 1'b1);
        compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("FAIL fullrw_overflow: got %b want 0", bus.overflow); end
        compared++; if (bus.full !== 1'b1) begin mismatched++; $display("FAIL fullrw_still_full: got %b want 1", bus.full); end
        compared++; if (bus.data_out !== m_dout || bus.data_out_valid !== 1'b1) begin mismatched++; $display("FAIL fullrw_read: got %h/%b want %h/1", bus.data_out, bus.data_out_valid, m_dout); end
`ifdef FIFO_OUT_COUNT_EN
        compared++; if (bus.rd_data_count !== 3'd4) begin mismatched++; $display("FAIL fullrw_count: got %0d want 4", bus.rd_data_count); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            compared++; if (bus.data_out !== m_dout) begin mismatched++; $display("FAIL fullrw_drain %0d: got %h want %h", i, bus.data_out, m_dout); end
        end
        compared++; if (bus.data_out !== new_word) begin mismatched++; $display("FAIL fullrw_last_word: got %h want %h", bus.data_out, new_word); end
        compared++; if (bus.empty !== 1'b1) begin mismatched++; $display("FAIL fullrw_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_empty_read();
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] held;
        held = m_dout;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'hFFFF, 1'b1);
            compared++; if (bus.data_out_valid !== 1'b0) begin mismatched++; $display("FAIL empty_rd_valid %0d: got %b want 0", i, bus.data_out_valid); end
            compared++; if (bus.data_out !== held) begin mismatched++; $display("FAIL empty_rd_hold %0d: got %h want %h", i, bus.data_out, held); end
        end
        // Model is at index 2 of the current frame: the pair (a,b) completes a word
        // while the buffer is empty, so the same-cycle read must be ignored.
        a = 16'($urandom);
        b = 16'($urandom);
        drive(1'b1, a, 1'b1);
        drive(1'b1, b, 1'b1);
        compared++; if (bus.data_out_valid !== 1'b0) begin mismatched++; $display("FAIL empty_rw_ignored: got %b want 0", bus.data_out_valid); end
        drive(1'b0, 16'h0000, 1'b1);
        compared++; if (bus.data_out !== {a, b} || bus.data_out_valid !== 1'b1) begin mismatched++; $display("FAIL empty_rw_next: got %h/%b want %h/1", bus.data_out, bus.data_out_valid, {a, b}); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pts [NFFT];
        logic [31:0] want;
        for (int c = 0; c < 15; c++) drive(1'b1, 16'($urandom), 1'b0);
        test_reset();
        for (int i = 0; i < NFFT; i++) begin
            pts[i] = 16'($urandom);
            drive(1'b1, pts[i], 1'b0);
        end
        compared++; if (bus.frame_done !== 1'b1) begin mismatched++; $display("FAIL rstmid_frame_done: got %b want 1", bus.frame_done); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0000, 1'b1);
            want = {pts[2 * i], pts[2 * i + 1]};
            compared++; if (bus.data_out !== want || bus.data_out_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_word %0d: got %h/%b want %h/1", i, bus.data_out, bus.data_out_valid, want); end
        end
        drive(1'b0, 16'h0000, 1'b0);
        compared++; if (bus.empty !== 1'b1) begin mismatched++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_random();
        logic v;
        logic r;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 4);
            drive(v, 16'($urandom), r);
            compared++; if (bus.data_out_valid !== e_valid) begin mismatched++; $display("FAIL rand_valid cyc %0d: got %b want %b", c, bus.data_out_valid, e_valid); end
            compared++; if (bus.data_out !== m_dout) begin mismatched++; $display("FAIL rand_data cyc %0d: got %h want %h", c, bus.data_out, m_dout); end
            compared++; if (bus.empty !== (q.size() == 0)) begin mismatched++; $display("FAIL rand_empty cyc %0d: got %b want %b", c, bus.empty, q.size() == 0); end
            compared++; if (bus.full !== (q.size() == DEPTH)) begin mismatched++; $display("FAIL rand_full cyc %0d: got %b want %b", c, bus.full, q.size() == DEPTH); end
            compared++; if (bus.frame_done !== e_fd) begin mismatched++; $display("FAIL rand_frame_done cyc %0d: got %b want %b", c, bus.frame_done, e_fd); end
            compared++; if (bus.overflow !== m_ovf) begin mismatched++; $display("FAIL rand_overflow cyc %0d: got %b want %b", c, bus.overflow, m_ovf); end
`ifdef FIFO_OUT_COUNT_EN
            compared++; if (int'(bus.rd_data_count) !== q.size()) begin mismatched++; $display("FAIL rand_count cyc %0d: got %0d want %0d", c, bus.rd_data_count, q.size()); end
`endif
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_full_rw();
        test_empty_read();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_out_pack.md
Name: fifo_out_pack

Overview:
- Return-path buffer for the range processing chain.
- Accepts the serial 16-bit FFT output stream, one point per valid clock, grouped in frames of NFFT points.
- Keeps the first KEEP_LENGTH points of each frame, discards the rest, and packs point pairs into 32-bit words.
- Holds the words in an internal ring buffer until the downstream 32-bit consumer drains it with a read request.
- This undoes the 32-to-16 split and zero-pad done on the FFT input side.

Parameters:
- NFFT, 1024, points per input frame; must be a power of two and at least 4.
- KEEP_LENGTH, 512, leading points kept per frame; must be even, at least 2 and at most NFFT.
- DEPTH, 2048, ring buffer depth in 32-bit words; must be a power of two.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  16  FFT output point.
- data_in_valid  input  1  data_in is valid this cycle.
- rd_req  input  1  consumer requests one 32-bit word.
- data_out  output  32  packed word; the earlier point is in [31:16], the later point in [15:0].
- data_out_valid  output  1  one-cycle strobe that qualifies data_out.
- empty  output  1  buffer holds no words.
- full  output  1  buffer holds DEPTH words.
- frame_done  output  1  one-cycle pulse after the last point (index NFFT-1) of a frame has been accepted.
- overflow  output  1  sticky; set when a packed word is dropped because the buffer is full.

Behaviour:
- Reset values: data_out=0, data_out_valid=0, empty=1, full=0, frame_done=0, overflow=0. Point counter, pointers, occupancy and pack register all clear to 0; state=WAIT_FRAME.
- Reset mid-operation discards all buffered words and any partial frame.
- Point counter, width clog2(NFFT):
  - advances only on cycles with data_in_valid=1; gaps in valid are allowed and do not affect framing;
  - wraps from NFFT-1 to 0.
- Input FSM, one-hot:
  - WAIT_FRAME: no valid point seen since reset. The first valid point is index 0; on it the FSM goes to KEEP.
  - KEEP: points with index < KEEP_LENGTH are captured. An even index loads the pack register [31:16]. An odd index completes the word with data_in in [15:0] and writes it the same edge. On accepting index KEEP_LENGTH-1: go to DISCARD if KEEP_LENGTH < NFFT, otherwise stay in KEEP.
  - DISCARD: valid points are counted and dropped. On accepting index NFFT-1, go to KEEP.
- frame_done is registered high for one cycle after index NFFT-1 is accepted, in either KEEP or DISCARD.
- Write path:
  - a write with full=1 drops the word and sets overflow; overflow stays high until rst;
  - a write with full=0 stores at wr_ptr and increments it modulo DEPTH.
- Read path:
  - rd_req=1 with empty=0 is accepted;
  - data_out is registered from rd_ptr and data_out_valid=1 on the next cycle (latency 1); rd_ptr increments;
  - rd_req=1 with empty=1 is ignored: no strobe, and data_out holds its last value.
- Occupancy and flags:
  - occupancy counter width clog2(DEPTH)+1; empty and full are registered from its next value;
  - a simultaneous accepted read and write leaves occupancy unchanged;
  - when full=1, a read and a write in the same cycle are both accepted, with no overflow;
  - when empty=1, a read in the same cycle as a write is ignored; the word is readable from the following cycle.

Optional Feature:
- Macro: FIFO_OUT_COUNT_EN.
- Defined: adds output port rd_data_count, width clog2(DEPTH)+1, equal to the registered occupancy; it resets to 0 and updates on the same edge as empty and full.
- Undefined: the port is absent and the occupancy counter is used only internally.

Decomposition:
- Shared package fifo_out_pkg holds:
  - one-hot state encodings WAIT_FRAME=3'b001, KEEP=3'b010, DISCARD=3'b100;
  - a constant clog2 function;
  - PACK_HI=[31:16] and PACK_LO=[15:0] slice constants.
- One sub-module, ring_buf_dp:
  - simple dual-port register or RAM array with registered read;
  - owns the pointers, occupancy, full and empty;
  - the top level keeps the framing FSM, point counter, packer and overflow.

Test Plan:
All scenarios use NFFT=8, KEEP_LENGTH=4, DEPTH=4 unless stated.
1. Feed points 0x0001..0x0008 continuously, then one rd_req per cycle. Expect two words, 0x00010002 and 0x00030004, each one cycle after its request; frame_done high for one cycle after point 8; empty=1 afterwards.
2. Feed the same frame with data_in_valid toggled every other cycle. Expect the same two words and a single frame_done pulse.
3. Feed three frames with no reads. Expect full=1 after 4 words, the 5th and 6th words dropped, overflow=1 and held until rst. Draining then returns the first 4 words in order.
4. With the buffer full, assert rd_req in the cycle a new word completes. Expect no overflow, occupancy stays 4, and the new word reads out last.
5. With empty=1, assert rd_req for 3 cycles. Expect data_out_valid=0 throughout and data_out unchanged.
6. Assert rst in the middle of frame 2. Expect all outputs at reset values; the next valid point is treated as index 0 and a full frame packs correctly. With FIFO_OUT_COUNT_EN defined, rd_data_count tracks 0..4 throughout these scenarios.
